spn_round_stage: RTL and testbench

// - One registered stage of the toy SPN block cipher.
// - Each cycle it computes, from state x, round key k and round index i:
//   - the key-addition result,
//   - the full round output,
//   - the next round key.
// - Encrypt datapaths (iterative or pipelined) instantiate it once per round.
// - The final ciphertext comes from a last key addition.

---
 rtl/spn_round_stage_pkg.sv | 45 ++++
 rtl/spn_round_stage_key_addition.sv | 14 +
 rtl/spn_round_stage_key_schedule.sv | 39 +++
 rtl/spn_round_stage_round.sv | 33 +++
 rtl/spn_round_stage.sv | 71 +++++++
 tb/tb_spn_round_stage.sv | 214 +++++++++++++++++++++
 6 files changed

// File: rtl/spn_round_stage_pkg.sv
// Shared parameters and helpers for the toy SPN round stage: default widths,
// the 4-bit S-box and the bit-permutation destination function.
package spn_round_stage_pkg;

    localparam int N_B_DEF = 16;
    localparam int N_K_DEF = 16;
    localparam int N_I_DEF = 5;

    // 4-bit substitution box, inputs 0..F.
    function automatic logic [3:0] sbox4(input logic [3:0] v);
        logic [3:0] r;
        case (v)
            4'h0: r = 4'hC;
            4'h1: r = 4'h5;
            4'h2: r = 4'h6;
            4'h3: r = 4'hB;
            4'h4: r = 4'h9;
            4'h5: r = 4'h0;
            4'h6: r = 4'hA;
            4'h7: r = 4'hD;
            4'h8: r = 4'h3;
            4'h9: r = 4'hE;
            4'hA: r = 4'hF;
            4'hB: r = 4'h8;
            4'hC: r = 4'h4;
            4'hD: r = 4'h7;
            4'hE: r = 4'h1;
            default: r = 4'h2;
        endcase
        return r;
    endfunction

    // Destination bit of input bit j in the permutation layer of an nb-bit
    // block. The top bit is a fixed point; the rest spread by stride nb/4.
    function automatic int perm_dst(input int j, input int nb);
        int r;
        if (j == nb - 1) begin
            r = nb - 1;
        end else begin
            r = (j * (nb / 4)) % (nb - 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/spn_round_stage_key_addition.sv
// Key addition: plain XOR of state and round key.
module key_addition
    import spn_round_stage_pkg::*;
#(
    parameter int N_B = N_B_DEF
) (
    output logic [N_B-1:0] r,
    input  logic [N_B-1:0] x,
    input  logic [N_B-1:0] k
);

    assign r = x ^ k;

endmodule

// File: rtl/spn_round_stage_key_schedule.sv
// Next round key: rotate left by 3, substitute the top nibble, mix in the
// zero-extended round index.
module key_schedule
    import spn_round_stage_pkg::*;
#(
    parameter int N_K = N_K_DEF,
    parameter int N_I = N_I_DEF
) (
    output logic [N_K-1:0] r,
    input  logic [N_K-1:0] x,
    input  logic [N_K-1:0] k,
    input  logic [N_I-1:0] i
);

    // x is carried only for a uniform port order across the round helpers;
    // the schedule depends on k and i alone.
    logic           unused_x;
    logic [N_K-1:0] rot;
    logic [N_K-1:0] idx_ext;
    logic [N_K-1:0] t;

    assign unused_x = ^x;
    assign rot      = {k[N_K-4:0], k[N_K-1 -: 3]};

    // Zero-extend the index without a zero-width replication when N_I == N_K.
    always_comb begin
        idx_ext          = '0;
        idx_ext[N_I-1:0] = i;
    end

    // Substitute the top nibble of the rotated key.
    always_comb begin
        t              = rot;
        t[N_K-1 -: 4]  = sbox4(rot[N_K-1 -: 4]);
    end

    assign r = t ^ idx_ext;

endmodule

// File: rtl/spn_round_stage_round.sv
// Full round: S-box layer on every nibble of x ^ k, then the bit permutation.
module round
    import spn_round_stage_pkg::*;
#(
    parameter int N_B = N_B_DEF
) (
    output logic [N_B-1:0] r,
    input  logic [N_B-1:0] x,
    input  logic [N_B-1:0] k
);

    logic [N_B-1:0] mixed;
    logic [N_B-1:0] subst;

    assign mixed = x ^ k;

    // Substitute each nibble independently.
    always_comb begin
        subst = '0;
        for (int n = 0; n < N_B / 4; n++) begin
            subst[n*4 +: 4] = sbox4(mixed[n*4 +: 4]);
        end
    end

    // Scatter each substituted bit to its permuted position.
    always_comb begin
        r = '0;
        for (int j = 0; j < N_B; j++) begin
            r[perm_dst(j, N_B)] = subst[j];
        end
    end

endmodule

// File: rtl/spn_round_stage.sv
// One registered SPN round stage: combinational key addition, round and key
// schedule feeding a bank of output registers with a valid flag.
//
// Flow control: in_valid qualifies x/k/idx for the current edge only; there is
// no ready, so every valid input is accepted and appears one cycle later with
// out_valid=1. Data registers load only on valid inputs and hold otherwise.
module spn_round_stage
    import spn_round_stage_pkg::*;
#(
    parameter int N_B = N_B_DEF,
    parameter int N_K = N_K_DEF,
    parameter int N_I = N_I_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic [N_B-1:0] x,
    input  logic [N_K-1:0] k,
    input  logic [N_I-1:0] idx,
    output logic           out_valid,
    output logic [N_B-1:0] add_out,
    output logic [N_B-1:0] round_out,
    output logic [N_K-1:0] key_out
);

    logic [N_B-1:0] add_c;
    logic [N_B-1:0] round_c;
    logic [N_K-1:0] key_c;

    key_addition #(.N_B(N_B)) u_key_addition (
        .r (add_c),
        .x (x),
        .k (k)
    );

    round #(.N_B(N_B)) u_round (
        .r (round_c),
        .x (x),
        .k (k)
    );

    key_schedule #(.N_K(N_K), .N_I(N_I)) u_key_schedule (
        .r (key_c),
        .x (x),
        .k (k),
        .i (idx)
    );

    // Valid flag follows in_valid; reset wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

    // Result registers capture only valid inputs and hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            add_out   <= '0;
            round_out <= '0;
            key_out   <= '0;
        end else if (in_valid) begin
            add_out   <= add_c;
            round_out <= round_c;
            key_out   <= key_c;
        end
    end

endmodule

// File: tb/tb_spn_round_stage.sv
// Self-checking bench for spn_round_stage with a behavioural model.
module tb_spn_round_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] x;
  logic [15:0] k;
  logic [4:0]  idx;
  logic        out_valid;
  logic [15:0] add_out;
  logic [15:0] round_out;
  logic [15:0] key_out;

  spn_round_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .x         (x),
    .k         (k),
    .idx       (idx),
    .out_valid (out_valid),
    .add_out   (add_out),
    .round_out (round_out),
    .key_out   (key_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int sbox_t [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

  function automatic logic [15:0] m_sub(input logic [15:0] v);
    logic [15:0] r;
    r = 0;
    for (int n = 0; n < 4; n++) begin
      int nib;
      nib = (v >> (4 * n)) & 15;
      r = r | 16'(sbox_t[nib] << (4 * n));
    end
    return r;
  endfunction

  function automatic logic [15:0] m_perm(input logic [15:0] v);
    logic [15:0] r;
    r = 0;
    for (int j = 0; j < 16; j++) begin
      int d;
      d = (j == 15) ? 15 : (j * 4) % 15;
      if (v[j]) r = r | 16'(1 << d);
    end
    return r;
  endfunction

  function automatic logic [15:0] m_key(input logic [15:0] kk, input logic [4:0] ii);
    int t;
    int top;
    t = ((int'(kk) * 8) + (int'(kk) / 8192)) % 65536;
    top = t / 4096;
    t = (t % 4096) + sbox_t[top] * 4096;
    return 16'(t) ^ {11'd0, ii};
  endfunction

  logic        m_valid;
  logic [15:0] m_add;
  logic [15:0] m_round;
  logic [15:0] m_keyo;
  logic        cmp_en = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 0; m_add = 0; m_round = 0; m_keyo = 0;
    end else if (in_valid) begin
      m_valid = 1;
      m_add   = x ^ k;
      m_round = m_perm(m_sub(x ^ k));
      m_keyo  = m_key(k, idx);
    end else begin
      m_valid = 0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_out_valid", {15'd0, out_valid}, {15'd0, m_valid});
      check("cmp_add_out", add_out, m_add);
      check("cmp_round_out", round_out, m_round);
      check("cmp_key_out", key_out, m_keyo);
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [15:0] xx, input logic [15:0] kk, input logic [4:0] ii);
    @(negedge clk);
    in_valid = v; x = xx; k = kk; idx = ii;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_q[$];
  logic [15:0] last_add;
  logic [15:0] rx, rk;
  logic [3:0]  s_lo;

  int sbox_lit [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

  initial begin
    rst_n = 0; in_valid = 1; x = 16'hA5A5; k = 16'h5A5A; idx = 5'd7;

    // reset with in_valid asserted for 2 cycles
    settle();
    settle();
    check("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_add_out", add_out, 16'd0);
    check("rst_round_out", round_out, 16'd0);
    check("rst_key_out", key_out, 16'd0);
    cmp_en = 1'b1;

    @(negedge clk);
    rst_n = 1; in_valid = 0;

    // hand-computed vectors
    drive(1, 16'h1234, 16'hFFFF, 5'd0);
    settle();
    check("lit_add_1234", add_out, 16'hEDCB);
    check("lit_valid_1234", {15'd0, out_valid}, 16'd1);

    drive(1, 16'h0000, 16'h0000, 5'd1);
    settle();
    check("lit_round_zero", round_out, 16'hFF00);
    check("lit_key_zero", key_out, 16'hC001);

    drive(1, 16'hFFFF, 16'hFFFF, 5'd0);
    settle();
    check("lit_add_ones", add_out, 16'h0000);
    check("lit_round_ones", round_out, 16'hFF00);
    check("lit_key_ones", key_out, 16'h2FFF);

    // pin the model itself
    check("model_round_zero", m_perm(m_sub(16'h0000)), 16'hFF00);
    check("model_key_ones", m_key(16'hFFFF, 5'd0), 16'h2FFF);

    // back-to-back valid inputs, results in order
    for (int n = 0; n < 4; n++) begin
      rx = 16'($urandom); rk = 16'($urandom);
      exp_q.push_back(rx ^ rk);
      drive(1, rx, rk, 5'($urandom_range(0, 31)));
      settle();
      check("b2b_valid", {15'd0, out_valid}, 16'd1);
      last_add = exp_q.pop_front();
      check("b2b_add", add_out, last_add);
    end
    drive(0, 16'($urandom), 16'($urandom), 5'($urandom));
    settle();
    check("drop_valid", {15'd0, out_valid}, 16'd0);
    check("drop_hold_add", add_out, last_add);
    drive(0, 16'($urandom), 16'($urandom), 5'($urandom));
    settle();
    check("drop_hold_add2", add_out, last_add);

    // S-box sweep on the low nibble, recovered through the permutation
    for (int v = 0; v < 16; v++) begin
      drive(1, 16'(v), 16'h0000, 5'd0);
      settle();
      s_lo = {round_out[12], round_out[8], round_out[4], round_out[0]};
      check("sbox_sweep", {12'd0, s_lo}, 16'(sbox_lit[v]));
    end

    // reset mid-stream discards the in-flight result
    drive(1, 16'h1111, 16'h2222, 5'd3);
    @(negedge clk);
    rst_n = 0; in_valid = 1; x = 16'h3333;
    settle();
    check("midrst_valid", {15'd0, out_valid}, 16'd0);
    check("midrst_add", add_out, 16'd0);
    @(negedge clk);
    rst_n = 1;
    drive(1, 16'h00F0, 16'h0F00, 5'd9);
    settle();
    check("post_rst_add", add_out, 16'h0FF0);

    // randomized traffic with don't-care inputs and occasional resets
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 39) != 0);
      in_valid = ($urandom_range(0, 9) < 7);
      x = 16'($urandom); k = 16'($urandom); idx = 5'($urandom);
    end
    @(negedge clk);
    rst_n = 1; in_valid = 0;
    settle();
    settle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
